dp_core_param: RTL and testbench

- Parametrised successor to the fixed 4-bit single-cycle datapath: register file, ALU, PC, and input/output port latches, all generalised in width and port count.
- Data memory is moved outside the block behind a registered-latency RAM interface.
- Loads are handled by an explicit wait state machine rather than a toggle bit.
- Sits between the instruction ROM/decoder (which supplies inst and the control strobes) and the board-level RAM/LED/switch logic.

---
 rtl/dp_pkg.sv | 30 +++
 rtl/dp_alu.sv | 53 +++++
 rtl/dp_regfile.sv | 25 ++
 rtl/dp_core_param.sv | 198 +++++++++++++++++++
 tb/tb_dp_core_param.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared constants for the parametrised datapath core: opcodes, inst field
// positions, ALU operation codes and the load-sequencing state type.
package dp_pkg;

  localparam logic [4:0] OP_LINK = 5'b10010;
  localparam logic [4:0] OP_LOAD = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_RDBK = 5'b10111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 11;
  localparam int RA1_MSB = 10;
  localparam int RA1_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 4;
  localparam int WA_MSB  = 3;
  localparam int WA_LSB  = 1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_PASB = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_SHR  = 4'd7;

  typedef enum logic {EXEC, WAIT} state_t;

endpackage

// File: rtl/dp_alu.sv
// Width-parametrised ALU; flags are {zero, carry/borrow, negative, overflow}.
module dp_alu
  import dp_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [W-1:0] y,
  output logic [3:0]   flags
);

  logic [W:0] sum;
  logic       c;
  logic       v;

  always_comb begin
    sum = '0;
    c   = 1'b0;
    v   = 1'b0;
    y   = a;
    case (ctrl)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        y   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
      end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_PASB: y = b;
      ALU_SHL: begin
        y = {a[W-2:0], 1'b0};
        c = a[W-1];
      end
      ALU_SHR: begin
        y = {1'b0, a[W-1:1]};
        c = a[0];
      end
      default:  y = a;
    endcase
    flags = {(y == '0), c, y[W-1], v};
  end

endmodule

// File: rtl/dp_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous write
// port, no reset and no write-to-read bypass.
module dp_regfile #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         we,
  input  logic [2:0]   wa,
  input  logic [W-1:0] wd,
  input  logic [2:0]   ra1,
  input  logic [2:0]   ra2,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2
);

  logic [W-1:0] mem [8];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/dp_core_param.sv
// Parametrised datapath core with external latency-RAM loads.
// Build option DP_PORT_READBACK_EN adds op 10111 (output latch -> register).
//
// state | meaning
// EXEC  | one instruction commits per non-stalled cycle; loads are issued here
// WAIT  | load outstanding; down-counter runs to 1, then RAM data is written back
module dp_core_param
  import dp_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int PC_W    = 4,
  parameter int N_OUT   = 2,
  parameter int N_IN    = 2,
  parameter int RAM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             inst,
  input  logic                    reg_write,
  input  logic                    mem_write,
  input  logic                    alu_src,
  input  logic                    pc_src,
  input  logic                    port_write,
  input  logic [3:0]              alu_control,
  input  logic                    stall,
  input  logic [N_IN*DATA_W-1:0]  port_in,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic [DATA_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  output logic                    ram_we,
  output logic [3:0]              alu_flags,
  output logic [PC_W-1:0]         pc,
  output logic [N_OUT*DATA_W-1:0] port_data,
  output logic                    busy
);

  localparam int CNT_W = $clog2(RAM_LAT + 1);

  logic [4:0] op;
  logic [2:0] ra1;
  logic [3:0] imm;
  logic [2:0] wa;

  assign op  = inst[OP_MSB:OP_LSB];
  assign ra1 = inst[RA1_MSB:RA1_LSB];
  assign imm = inst[IMM_MSB:IMM_LSB];
  assign wa  = inst[WA_MSB:WA_LSB];

  logic unused_inst_lsb;
  assign unused_inst_lsb = inst[0];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [2:0]        lwa_q, lwa_d;
  logic              lrw_q, lrw_d;
  logic [DATA_W-1:0] lat_q [N_OUT];

  logic [DATA_W-1:0] src1, rd2, src2, alu_y, in_sel;
  logic              rf_we, lat_we;
  logic [2:0]        rf_wa;
  logic [DATA_W-1:0] rf_wd;

  dp_regfile #(.W(DATA_W)) u_rf (
    .clk (clk),
    .we  (rf_we & ~rst),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .ra1 (ra1),
    .ra2 (imm[2:0]),
    .rd1 (src1),
    .rd2 (rd2)
  );

  assign src2 = alu_src ? DATA_W'(imm) : rd2;

  dp_alu #(.W(DATA_W)) u_alu (
    .a     (src1),
    .b     (src2),
    .ctrl  (alu_control),
    .y     (alu_y),
    .flags (alu_flags)
  );

  assign pc_inc = pc_q + 1'b1;

  always_comb begin
    in_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (src2 == DATA_W'(k)) in_sel = port_in[k*DATA_W +: DATA_W];
    end
  end

`ifdef DP_PORT_READBACK_EN
  logic [DATA_W-1:0] rdbk_sel;
  always_comb begin
    rdbk_sel = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (src2 == DATA_W'(k)) rdbk_sel = lat_q[k];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    lwa_d   = lwa_q;
    lrw_d   = lrw_q;
    rf_we   = 1'b0;
    rf_wa   = wa;
    rf_wd   = alu_y;
    lat_we  = 1'b0;
    if (!stall) begin
      case (state_q)
        EXEC: begin
          if (op == OP_LOAD) begin
            // pc holds; it advances when the data comes back
            state_d = WAIT;
            cnt_d   = CNT_W'(RAM_LAT);
            lwa_d   = wa;
            lrw_d   = reg_write;
          end else begin
            pc_d   = pc_src ? PC_W'(src2) : pc_inc;
            lat_we = port_write;
            casez (op)
              5'b0????: begin
                rf_we = reg_write;
                rf_wd = alu_y;
              end
              OP_LINK: begin
                rf_we = reg_write;
                rf_wd = DATA_W'(pc_inc);
              end
              OP_IN: begin
                rf_we = reg_write;
                rf_wd = in_sel;
              end
`ifdef DP_PORT_READBACK_EN
              OP_RDBK: begin
                rf_we = reg_write;
                rf_wd = rdbk_sel;
              end
`endif
              default: rf_we = 1'b0;
            endcase
          end
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            rf_we   = lrw_q;
            rf_wa   = lwa_q;
            rf_wd   = ram_rdata;
            pc_d    = pc_inc;
            state_d = EXEC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EXEC;
      cnt_q   <= '0;
      pc_q    <= '0;
      lwa_q   <= '0;
      lrw_q   <= 1'b0;
      for (int k = 0; k < N_OUT; k++) lat_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      lwa_q   <= lwa_d;
      lrw_q   <= lrw_d;
      if (lat_we) begin
        for (int k = 0; k < N_OUT; k++) begin
          if (src2 == DATA_W'(k)) lat_q[k] <= src1;
        end
      end
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_port
    assign port_data[g*DATA_W +: DATA_W] = lat_q[g];
  end

  assign pc        = pc_q;
  assign busy      = (state_q == WAIT);
  assign ram_addr  = src2;
  assign ram_wdata = src1;
  assign ram_we    = mem_write & (state_q == EXEC) & ~stall & ~rst;

endmodule

// File: tb/tb_dp_core_param.sv
// Scoreboard bench for dp_core_param (DATA_W=8, PC_W=4, 2 in/2 out, RAM_LAT=3);
// register contents are observed through ram_wdata (= reg[ra1]).
module tb_dp_core_param;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam int NO = 2;
  localparam int NI = 2;
  localparam int RL = 3;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_OTH  = 5'b11000;
  localparam logic [4:0] OP_LINK = 5'b10010;
  localparam logic [4:0] OP_LOAD = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_RDBK = 5'b10111;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_PASB = 4'd5;

  logic          clk, rst;
  logic [15:0]   inst;
  logic          reg_write, mem_write, alu_src, pc_src, port_write, stall;
  logic [3:0]    alu_control;
  logic [NI*DW-1:0] port_in;
  logic [DW-1:0] ram_rdata, ram_addr, ram_wdata;
  logic          ram_we, busy;
  logic [3:0]    alu_flags;
  logic [PW-1:0] pc;
  logic [NO*DW-1:0] port_data;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct { int r; logic [DW-1:0] v; } exp_t;
  exp_t sb[$];

  dp_core_param #(.DATA_W(DW), .PC_W(PW), .N_OUT(NO), .N_IN(NI), .RAM_LAT(RL)) dut (
    .clk(clk), .rst(rst), .inst(inst), .reg_write(reg_write), .mem_write(mem_write),
    .alu_src(alu_src), .pc_src(pc_src), .port_write(port_write),
    .alu_control(alu_control), .stall(stall), .port_in(port_in),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .alu_flags(alu_flags), .pc(pc), .port_data(port_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // RAM model: fixed contents, RL-stage registered read pipeline
  logic [DW-1:0] pipe [RL];
  always @(posedge clk) begin
    pipe[0] <= (ram_addr == 8'h04) ? 8'hA5 : (ram_addr ^ 8'h5A);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_rdata = pipe[RL-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] ra1, input logic [3:0] imm,
                       input logic [2:0] wa, input logic rw, input logic asrc,
                       input logic psrc, input logic pw, input logic mw, input logic [3:0] ac);
    inst        = {op, ra1, imm, wa, 1'b0};
    reg_write   = rw;
    alu_src     = asrc;
    pc_src      = psrc;
    port_write  = pw;
    mem_write   = mw;
    alu_control = ac;
    stall       = 1'b0;
    #1;
  endtask

  task automatic nop();
    drive(OP_ALU, 3'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
  endtask

  // combinational peek of reg[r]; stall is held so no state can move
  task automatic peek(input int r, output logic [DW-1:0] v);
    logic [2:0] sv_ra;
    logic       sv_st;
    sv_ra = inst[10:8];
    sv_st = stall;
    inst[10:8] = r[2:0];
    stall = 1'b1;
    #1;
    v = ram_wdata;
    inst[10:8] = sv_ra;
    stall = sv_st;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_write = 1'b1;
    #1;
    n_cmp++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
    tick();
    rst = 1'b0;
    nop();
    n_cmp++;
    if (pc !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (port_data !== 16'h0000) begin n_fail++; $display("FAIL reset_port_data: got %h expected 0000", port_data); end
  endtask

  task automatic test_alu();
    exp_t e;
    logic [DW-1:0] got;
    drive(OP_ALU, 3'd0, 4'd5, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_PASB);
    sb.push_back('{1, 8'd5});
    tick();
    n_cmp++;
    if (pc !== 4'd1) begin n_fail++; $display("FAIL alu_pc1: got %0d expected 1", pc); end
    drive(OP_ALU, 3'd0, 4'd9, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_PASB);
    sb.push_back('{2, 8'd9});
    tick();
    n_cmp++;
    if (pc !== 4'd2) begin n_fail++; $display("FAIL alu_pc2: got %0d expected 2", pc); end
    // 5 - 9 = 0xFC: borrow and negative set, no overflow
    drive(OP_ALU, 3'd1, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A_SUB);
    n_cmp++;
    if (alu_flags !== 4'b0110) begin n_fail++; $display("FAIL alu_sub_flags: got %b expected 0110", alu_flags); end
    drive(OP_ALU, 3'd1, 4'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    n_cmp++;
    if (alu_flags !== 4'b0000) begin n_fail++; $display("FAIL alu_add_flags: got %b expected 0000", alu_flags); end
    sb.push_back('{3, 8'd14});
    tick();
    nop();
    n_cmp++;
    if (pc !== 4'd3) begin n_fail++; $display("FAIL alu_pc3: got %0d expected 3", pc); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.r, got);
      n_cmp++;
      if (got !== e.v) begin n_fail++; $display("FAIL alu_reg r%0d: got %h expected %h", e.r, got, e.v); end
    end
  endtask

  task automatic test_load();
    exp_t e;
    logic [DW-1:0] got;
    int cycles;
    drive(OP_LOAD, 3'd0, 4'd4, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
    n_cmp++;
    if (ram_addr !== 8'h04) begin n_fail++; $display("FAIL load_addr: got %h expected 04", ram_addr); end
    sb.push_back('{1, 8'hA5});
    tick();
    // would overwrite r1 with 4 if WAIT did not ignore it
    drive(OP_ALU, 3'd0, 4'd4, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_PASB);
    cycles = 0;
    while (busy === 1'b1 && cycles < 10) begin
      n_cmp++;
      if (pc !== 4'd3) begin n_fail++; $display("FAIL load_pc_hold: got %0d expected 3", pc); end
      peek(1, got);
      n_cmp++;
      if (got !== 8'd5) begin n_fail++; $display("FAIL load_early_write: got %h expected 05", got); end
      tick();
      cycles++;
    end
    nop();
    n_cmp++;
    if (cycles != RL) begin n_fail++; $display("FAIL load_busy_cycles: got %0d expected %0d", cycles, RL); end
    n_cmp++;
    if (pc !== 4'd4) begin n_fail++; $display("FAIL load_pc_after: got %0d expected 4", pc); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.r, got);
      n_cmp++;
      if (got !== e.v) begin n_fail++; $display("FAIL load_reg r%0d: got %h expected %h", e.r, got, e.v); end
    end
  endtask

  task automatic test_stall_reset();
    exp_t e;
    logic [DW-1:0] got;
    int cycles;
    drive(OP_ALU, 3'd0, 4'd3, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_PASB);
    tick();
    drive(OP_LOAD, 3'd0, 4'd4, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
    sb.push_back('{5, 8'hA5});
    tick();
    cycles = 0;
    while (busy === 1'b1 && cycles < 12) begin
      stall = (cycles == 1 || cycles == 2);
      #1;
      if (stall) begin
        n_cmp++;
        if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wait_ram_we: got %b expected 0", ram_we); end
      end
      tick();
      cycles++;
    end
    stall = 1'b0;
    nop();
    n_cmp++;
    if (cycles != RL + 2) begin n_fail++; $display("FAIL stall_busy_cycles: got %0d expected %0d", cycles, RL + 2); end
    n_cmp++;
    if (pc !== 4'd6) begin n_fail++; $display("FAIL stall_pc_after: got %0d expected 6", pc); end
    // reset in the middle of a load into r2 (holds 9)
    drive(OP_LOAD, 3'd0, 4'd4, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nop();
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_wait_busy: got %b expected 0", busy); end
    n_cmp++;
    if (pc !== 4'd0) begin n_fail++; $display("FAIL rst_wait_pc: got %0d expected 0", pc); end
    for (int i = 0; i < 4; i++) tick();
    sb.push_back('{2, 8'd9});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.r, got);
      n_cmp++;
      if (got !== e.v) begin n_fail++; $display("FAIL stall_rst_reg r%0d: got %h expected %h", e.r, got, e.v); end
    end
  endtask

  task automatic test_ports();
    exp_t e;
    logic [DW-1:0] got;
    drive(OP_ALU, 3'd0, 4'd15, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_PASB);
    tick();
    drive(OP_ALU, 3'd6, 4'd6, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    tick();
    drive(OP_ALU, 3'd6, 4'd6, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, A_ADD);
    sb.push_back('{6, 8'h3C});
    tick();
    drive(OP_ALU, 3'd6, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A_ADD);
    tick();
    nop();
    n_cmp++;
    if (port_data !== 16'h3C00) begin n_fail++; $display("FAIL port_wr1: got %h expected 3c00", port_data); end
    drive(OP_ALU, 3'd3, 4'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A_ADD);
    tick();
    nop();
    n_cmp++;
    if (port_data !== 16'h3C00) begin n_fail++; $display("FAIL port_wr_oob: got %h expected 3c00", port_data); end
    drive(OP_ALU, 3'd0, 4'd8, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_PASB);
    tick();
    drive(OP_ALU, 3'd7, 4'd9, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
    sb.push_back('{7, 8'h11});
    tick();
    drive(OP_ALU, 3'd7, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, A_ADD);
    tick();
    nop();
    n_cmp++;
    if (port_data !== 16'h3C11) begin n_fail++; $display("FAIL port_wr0: got %h expected 3c11", port_data); end
    port_in = 16'h7E00;
    drive(OP_IN, 3'd0, 4'd1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
    sb.push_back('{4, 8'h7E});
    tick();
    drive(OP_IN, 3'd0, 4'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
    sb.push_back('{0, 8'h00});
    tick();
    nop();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.r, got);
      n_cmp++;
      if (got !== e.v) begin n_fail++; $display("FAIL ports_reg r%0d: got %h expected %h", e.r, got, e.v); end
    end
  endtask

  task automatic test_jump_link();
    exp_t e;
    logic [DW-1:0] got;
    drive(OP_ALU, 3'd0, 4'd15, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A_ADD);
    tick();
    n_cmp++;
    if (pc !== 4'd15) begin n_fail++; $display("FAIL jump15: got %0d expected 15", pc); end
    drive(OP_LINK, 3'd0, 4'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
    sb.push_back('{3, 8'h00});
    tick();
    n_cmp++;
    if (pc !== 4'd0) begin n_fail++; $display("FAIL link_wrap_pc: got %0d expected 0", pc); end
    drive(OP_ALU, 3'd0, 4'd9, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, A_ADD);
    tick();
    n_cmp++;
    if (pc !== 4'd9) begin n_fail++; $display("FAIL jump9: got %0d expected 9", pc); end
    drive(OP_ALU, 3'd0, 4'd3, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, A_ADD);
    stall = 1'b1;
    #1;
    n_cmp++;
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL stall_ram_we: got %b expected 0", ram_we); end
    tick();
    n_cmp++;
    if (pc !== 4'd9) begin n_fail++; $display("FAIL stall_pc_freeze: got %0d expected 9", pc); end
    stall = 1'b0;
    #1;
    n_cmp++;
    if (ram_we !== 1'b1) begin n_fail++; $display("FAIL store_ram_we: got %b expected 1", ram_we); end
    drive(OP_OTH, 3'd0, 4'd7, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_PASB);
    sb.push_back('{2, 8'd9});
    tick();
    nop();
    n_cmp++;
    if (pc !== 4'd10) begin n_fail++; $display("FAIL other_pc: got %0d expected 10", pc); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.r, got);
      n_cmp++;
      if (got !== e.v) begin n_fail++; $display("FAIL jump_reg r%0d: got %h expected %h", e.r, got, e.v); end
    end
  endtask

  task automatic test_readback();
    exp_t e;
    logic [DW-1:0] got;
    drive(OP_RDBK, 3'd0, 4'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
`ifdef DP_PORT_READBACK_EN
    sb.push_back('{2, 8'h11});
`else
    sb.push_back('{2, 8'd9});
`endif
    tick();
    drive(OP_RDBK, 3'd0, 4'd2, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A_ADD);
`ifdef DP_PORT_READBACK_EN
    sb.push_back('{5, 8'h00});
`else
    sb.push_back('{5, 8'hA5});
`endif
    tick();
    nop();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      peek(e.r, got);
      n_cmp++;
      if (got !== e.v) begin n_fail++; $display("FAIL rdbk_reg r%0d: got %h expected %h", e.r, got, e.v); end
    end
  endtask

  initial begin
    rst = 1'b1;
    inst = '0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    alu_src = 1'b0;
    pc_src = 1'b0;
    port_write = 1'b0;
    alu_control = '0;
    stall = 1'b0;
    port_in = '0;
    #1;
    test_reset();
    test_alu();
    test_load();
    test_stall_reset();
    test_ports();
    test_jump_link();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
